tempo_alarm: RTL and testbench

TEMPO_ALARM -- requirements
Module: tempo_alarm

---
 rtl/tempo_pkg.sv | 14 +
 rtl/tempo_tick_det.sv | 29 ++
 rtl/tempo_alarm.sv | 118 +++++++++++
 tb/tb_tempo_alarm.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tempo_pkg.sv
// Shared types for the tempo alarm: tempo width, tempo value type and FSM state encoding.
package tempo_pkg;

  localparam int TEMPO_W = 7;

  typedef logic [TEMPO_W-1:0] tempo_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_e;

endpackage

// File: rtl/tempo_tick_det.sv
// Tick/skip detector: registers tempo each cycle and flags a +1 step (tick, 127->0 wraps)
// or any other change (skip).
module tempo_tick_det
  import tempo_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  tempo_t tempo,
  output logic   tick,
  output logic   skip
);

  tempo_t tempo_q;
  tempo_t tempo_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tempo_q <= '0;
    end else begin
      tempo_q <= tempo;
    end
  end

  // 7-bit add so 127 + 1 wraps to 0 and still counts as a tick.
  assign tempo_inc = tempo_q + tempo_t'(1);
  assign tick      = (tempo == tempo_inc);
  assign skip      = (tempo != tempo_q) && !tick;

endmodule

// File: rtl/tempo_alarm.sv
// Relative-delay alarm on a free-running 7-bit tempo counter.
// Define TEMPO_ALARM_RELOAD_EN to make the alarm periodic using the last accepted delta.
module tempo_alarm
  import tempo_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  tempo_t tempo,
  input  logic   load,
  input  tempo_t delta,
  input  logic   cancel,
  output logic   busy,
  output logic   alarm,
  output tempo_t remaining,
  output logic   skip_err
);

  logic   tick;
  logic   skip;
  state_e state_q, state_d;
  tempo_t remaining_q, remaining_d;
  logic   skip_err_q, skip_err_d;

  tempo_tick_det u_tick_det (
    .clk   (clk),
    .rst_n (rst_n),
    .tempo (tempo),
    .tick  (tick),
    .skip  (skip)
  );

`ifdef TEMPO_ALARM_RELOAD_EN
  tempo_t reload_q, reload_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      skip_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      skip_err_q  <= skip_err_d;
    end
  end

  // A load clears the sticky flag even if a skip is seen in the same cycle.
  assign skip_err_d = load ? 1'b0 : (skip_err_q | skip);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
`ifdef TEMPO_ALARM_RELOAD_EN
    reload_d    = reload_q;
`endif
    if (cancel) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else if (load) begin
`ifdef TEMPO_ALARM_RELOAD_EN
      reload_d = delta;
`endif
      if (delta == '0) begin
        state_d     = FIRED;
        remaining_d = '0;
      end else begin
        state_d     = ARMED;
        remaining_d = delta;
      end
    end else begin
      case (state_q)
        ARMED: begin
          if (tick) begin
            if (remaining_q == tempo_t'(1)) begin
              state_d     = FIRED;
              remaining_d = '0;
            end else begin
              remaining_d = remaining_q - tempo_t'(1);
            end
          end
        end
        FIRED: begin
`ifdef TEMPO_ALARM_RELOAD_EN
          if (reload_q != '0) begin
            state_d     = ARMED;
            remaining_d = reload_q;
          end else begin
            state_d     = IDLE;
            remaining_d = '0;
          end
`else
          state_d     = IDLE;
          remaining_d = '0;
`endif
        end
        default: begin
          state_d     = IDLE;
          remaining_d = '0;
        end
      endcase
    end
  end

  assign busy      = (state_q == ARMED);
  assign alarm     = (state_q == FIRED);
  assign remaining = remaining_q;
  assign skip_err  = skip_err_q;

endmodule

// File: tb/tb_tempo_alarm.sv
// Self-checking bench for tempo_alarm: expected alarm cycles are queued when the
// final tick is driven and matched by a monitor when alarm pulses.
module tb_tempo_alarm;

  logic       clk;
  logic       rst_n;
  logic [6:0] tempo;
  logic       load;
  logic [6:0] delta;
  logic       cancel;
  logic       busy;
  logic       alarm;
  logic [6:0] remaining;
  logic       skip_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [31:0] exp_q[$];

  tempo_alarm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tempo     (tempo),
    .load      (load),
    .delta     (delta),
    .cancel    (cancel),
    .busy      (busy),
    .alarm     (alarm),
    .remaining (remaining),
    .skip_err  (skip_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Driver: apply inputs, let one edge sample them, return #1 after that edge.
  task automatic drive(input int t, input bit l, input int d, input bit c);
    tempo  = 7'(t);
    load   = l;
    delta  = 7'(d);
    cancel = c;
    @(posedge clk);
    #1;
  endtask

  // Final tick is sampled by the next edge; alarm is visible in the cycle after it.
  task automatic expect_alarm_next();
    exp_q.push_back(32'(cyc + 1));
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() != 0 && int'(exp_q[0]) < cyc) begin
        check("missed_alarm", cyc, int'(exp_q.pop_front()));
      end
      if (alarm) begin
        if (exp_q.size() == 0) check("unexpected_alarm", 1, 0);
        else check("alarm_cycle", cyc, int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0; tempo = '0; load = 1'b0; delta = '0; cancel = 1'b0;
    #3;
    check("rst_busy", int'(busy), 0);
    check("rst_alarm", int'(alarm), 0);
    check("rst_remaining", int'(remaining), 0);
    check("rst_skip_err", int'(skip_err), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Tempo 0 -> 9 after reset is a jump
    drive(9, 0, 0, 0);
    check("jump_sets_skip", int'(skip_err), 1);

    // Counter 10..30, delta 5 at tempo 10
    drive(10, 1, 5, 0);
    check("t1_busy", int'(busy), 1);
    check("t1_rem_load", int'(remaining), 5);
    check("t1_load_clears_skip", int'(skip_err), 0);
    for (int t = 11; t <= 15; t++) begin
      if (t == 15) expect_alarm_next();
      drive(t, 0, 0, 0);
      check("t1_rem", int'(remaining), 15 - t);
      check("t1_busy_run", int'(busy), (t != 15) ? 1 : 0);
    end
    check("t1_alarm_hi", int'(alarm), 1);
    drive(16, 0, 0, 0);
    check("t1_alarm_lo", int'(alarm), 0);
    check("t1_busy_end", int'(busy), 0);
    for (int t = 17; t <= 30; t++) drive(t, 0, 0, 0);

    // Wrap 126 -> 127 -> 0 -> 1
    drive(125, 0, 0, 0);
    drive(126, 1, 3, 0);
    check("t2_rem_load", int'(remaining), 3);
    drive(127, 0, 0, 0);
    check("t2_rem_127", int'(remaining), 2);
    drive(0, 0, 0, 0);
    check("t2_rem_0", int'(remaining), 1);
    check("t2_skip_0", int'(skip_err), 0);
    expect_alarm_next();
    drive(1, 0, 0, 0);
    check("t2_alarm", int'(alarm), 1);
    check("t2_skip_1", int'(skip_err), 0);
    drive(2, 0, 0, 0);

    // Load+cancel while armed: cancel wins
    drive(3, 1, 4, 0);
    check("t3_rem_load", int'(remaining), 4);
    drive(4, 1, 2, 1);
    check("t3_busy_cancel", int'(busy), 0);
    check("t3_rem_cancel", int'(remaining), 0);
    for (int t = 5; t <= 14; t++) drive(t, 0, 0, 0);
    check("t3_busy_after", int'(busy), 0);

    // Skip 20 -> 25 while armed with 3 left
    drive(20, 1, 3, 0);
    check("t4_rem_load", int'(remaining), 3);
    drive(25, 0, 0, 0);
    check("t4_skip_set", int'(skip_err), 1);
    check("t4_rem_hold", int'(remaining), 3);
    drive(26, 0, 0, 0);
    check("t4_rem_tick", int'(remaining), 2);
    check("t4_skip_sticky", int'(skip_err), 1);
    drive(27, 1, 6, 0);
    check("t4_load_clear", int'(skip_err), 0);
    check("t4_rem_reload", int'(remaining), 6);
    drive(28, 0, 0, 1);

    // Asynchronous reset mid-ARMED
    drive(29, 1, 5, 0);
    for (int t = 30; t <= 32; t++) drive(t, 0, 0, 0);
    check("t5_rem_pre", int'(remaining), 2);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy_async", int'(busy), 0);
    check("t5_rem_async", int'(remaining), 0);
    check("t5_alarm_async", int'(alarm), 0);
    tempo = 7'd33;
    repeat (2) @(posedge clk);
    #1;
    tempo = 7'd1;
    rst_n = 1'b1;
    drive(1, 0, 0, 0);
    check("t5_tempo_q_zero", int'(skip_err), 0);
    for (int t = 2; t <= 10; t++) drive(t, 0, 0, 0);
    check("t5_busy_post", int'(busy), 0);
    check("t5_rem_post", int'(remaining), 0);

    // Delta 0 fires immediately for one cycle
    expect_alarm_next();
    drive(11, 1, 0, 0);
    check("t6_alarm_d0", int'(alarm), 1);
    drive(12, 0, 0, 0);
    check("t6_alarm_d0_lo", int'(alarm), 0);

`ifdef TEMPO_ALARM_RELOAD_EN
    // Periodic alarm: 4 ticks + FIRED = every 5 cycles
    drive(13, 1, 4, 0);
    for (int i = 1; i <= 15; i++) begin
      if (i % 5 == 4) expect_alarm_next();
      drive(13 + i, 0, 0, 0);
      if (i % 5 == 4) check("t7_rem_fired", int'(remaining), 0);
      else if (i % 5 == 0) check("t7_rem_reload", int'(remaining), 4);
      else check("t7_rem", int'(remaining), 4 - (i % 5));
    end
    drive(29, 0, 0, 1);
    check("t7_busy_cancel", int'(busy), 0);
    for (int t = 30; t <= 45; t++) drive(t, 0, 0, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
